// File: rtl/hazard_scoreboard.sv
// ============================================================================
// hazard_scoreboard
// ----------------------------------------------------------------------------
// Producer-side companion to the EX-stage forwarding unit, located in ID.
// Every issued instruction that writes a nonzero rd arms a per-register
// countdown. The countdown holds the number of cycles until that result can
// be forwarded. A separate countdown tracks occupancy of the multi-cycle
// (MUL/DIV) unit. If the instruction in ID reads a register whose countdown
// is still running, the scoreboard stalls PC and IF/ID and zeroes the ID/EX
// control word. It does the same if the instruction rewrites such a register
// (WAW), or if it needs the busy multi-cycle unit.
//
// Parameters
//   LOAD_LAT  extra cycles before a load result is forwardable (ALU: 0)
//   LONG_LAT  cycles before a MUL/DIV result is forwardable (>= 1)
//   CNT_W     countdown width; 2**CNT_W must exceed max(LOAD_LAT, LONG_LAT)
//
// Ports
//   clk, rst_n        pipeline clock, asynchronous active-low reset
//   ID_valid          ID holds a real instruction
//   ID_rs1/ID_rs2     source addresses, qualified by ID_rs1_used/ID_rs2_used
//   ID_rd             destination address, qualified by ID_RegWrite
//   ID_MemRead        instruction is a load
//   ID_Long           instruction uses the multi-cycle unit
//   flush             branch/jump flush of IF/ID this cycle
//   ext_stall         whole-pipeline freeze; all countdowns hold
//   stall             hold PC and IF/ID (combinational)
//   ID_EX_bubble      zero ID/EX control signals this cycle
//   long_busy         multi-cycle unit occupied
//   stall_cycles      (HAZARD_STATS_EN only) saturating count of cycles with
//                     stall=1 and ext_stall=0
//
// Configuration macro: HAZARD_STATS_EN adds the stall_cycles statistics port.
// Register address width comes from `REG_ADDR_WIDTH (5 if not defined).
// ============================================================================
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module hazard_scoreboard #(
    parameter int LOAD_LAT = 1,
    parameter int LONG_LAT = 4,
    parameter int CNT_W    = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ID_valid,
    input  logic [`REG_ADDR_WIDTH-1:0] ID_rs1,
    input  logic [`REG_ADDR_WIDTH-1:0] ID_rs2,
    input  logic                       ID_rs1_used,
    input  logic                       ID_rs2_used,
    input  logic [`REG_ADDR_WIDTH-1:0] ID_rd,
    input  logic                       ID_RegWrite,
    input  logic                       ID_MemRead,
    input  logic                       ID_Long,
    input  logic                       flush,
    input  logic                       ext_stall,
`ifdef HAZARD_STATS_EN
    output logic [31:0]                stall_cycles,
`endif
    output logic                       stall,
    output logic                       ID_EX_bubble,
    output logic                       long_busy
);

    localparam int               AW       = `REG_ADDR_WIDTH;
    localparam int               NREG     = 1 << AW;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] LONG_VAL = CNT_W'(LONG_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // ------------------------------------------------------------------
    // State: one countdown per architectural register (x0 never tracked)
    // plus the multi-cycle unit occupancy countdown.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [1:NREG-1];
    logic [CNT_W-1:0] cnt_d [1:NREG-1];
    logic [CNT_W-1:0] long_cnt_q;
    logic [CNT_W-1:0] long_cnt_d;

    // pending[i] = register i has a result that is not yet forwardable.
    // Bit 0 is tied low so x0 sources/destinations never hazard.
    logic [NREG-1:0] pending;

    logic id_live;
    logic raw_hazard;
    logic waw_hazard;
    logic struct_hazard;
    logic issue;
    logic rd_tracked;
    logic [CNT_W-1:0] rd_load_val;

    always_comb begin
        pending    = '0;
        for (int i = 1; i < NREG; i++) begin
            pending[i] = (cnt_q[i] != CNT_ZERO);
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection (combinational, zero-cycle from ID inputs).
    // A flushed ID slot is dead, so it can neither stall nor issue.
    // ------------------------------------------------------------------
    always_comb begin
        id_live       = ID_valid && !flush;
        raw_hazard    = id_live &&
                        ((ID_rs1_used && pending[ID_rs1]) ||
                         (ID_rs2_used && pending[ID_rs2]));
        waw_hazard    = id_live && ID_RegWrite && pending[ID_rd];
        struct_hazard = id_live && ID_Long && (long_cnt_q != CNT_ZERO);
        stall         = raw_hazard || waw_hazard || struct_hazard;
        ID_EX_bubble  = stall || flush;
        issue         = ID_valid && !stall && !flush && !ext_stall;
        long_busy     = (long_cnt_q != CNT_ZERO);
    end

    // Latency class of the issuing producer: long ops dominate loads, and
    // plain ALU results are forwardable immediately.
    always_comb begin
        rd_tracked = issue && ID_RegWrite && (ID_rd != '0);
        if (ID_Long) begin
            rd_load_val = LONG_VAL;
        end else if (ID_MemRead) begin
            rd_load_val = LOAD_VAL;
        end else begin
            rd_load_val = CNT_ZERO;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: freeze under ext_stall, otherwise decrement every running
    // countdown. A newly issued producer then overwrites its own entry.
    // The overwrite therefore beats the same-cycle decrement of that entry.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        long_cnt_d = long_cnt_q;

        if (!ext_stall) begin
            for (int i = 1; i < NREG; i++) begin
                if (cnt_q[i] != CNT_ZERO) begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end
            end
            if (long_cnt_q != CNT_ZERO) begin
                long_cnt_d = long_cnt_q - CNT_ONE;
            end

            if (rd_tracked) begin
                for (int i = 1; i < NREG; i++) begin
                    if (ID_rd == AW'(i)) begin
                        cnt_d[i] = rd_load_val;
                    end
                end
            end
            if (issue && ID_Long) begin
                long_cnt_d = LONG_VAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
            long_cnt_q <= CNT_ZERO;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            long_cnt_q <= long_cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    // ------------------------------------------------------------------
    // Stall statistics: cycles lost to hazards, excluding cycles in which
    // the whole pipeline is frozen anyway. Saturates instead of wrapping.
    // ------------------------------------------------------------------
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && !ext_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// tb_hazard_scoreboard
// Directed-vector bench for hazard_scoreboard with default parameters
// (LOAD_LAT=1, LONG_LAT=4). Inputs change 1 ns after a rising edge and
// outputs are sampled 1 ns later, well away from the next edge.
// ============================================================================
`timescale 1ns/1ps

module tb_hazard_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       ID_valid;
    logic [4:0] ID_rs1;
    logic [4:0] ID_rs2;
    logic       ID_rs1_used;
    logic       ID_rs2_used;
    logic [4:0] ID_rd;
    logic       ID_RegWrite;
    logic       ID_MemRead;
    logic       ID_Long;
    logic       flush;
    logic       ext_stall;
    logic       stall;
    logic       ID_EX_bubble;
    logic       long_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ID_valid     (ID_valid),
        .ID_rs1       (ID_rs1),
        .ID_rs2       (ID_rs2),
        .ID_rs1_used  (ID_rs1_used),
        .ID_rs2_used  (ID_rs2_used),
        .ID_rd        (ID_rd),
        .ID_RegWrite  (ID_RegWrite),
        .ID_MemRead   (ID_MemRead),
        .ID_Long      (ID_Long),
        .flush        (flush),
        .ext_stall    (ext_stall),
`ifdef HAZARD_STATS_EN
        .stall_cycles (stall_cycles),
`endif
        .stall        (stall),
        .ID_EX_bubble (ID_EX_bubble),
        .long_busy    (long_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present one instruction in ID: (rs1, rs1_used, rs2, rs2_used, rd, RegWrite, MemRead, Long)
    task automatic id_op(input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd,  input logic rw,
                         input logic mr,        input logic lg);
        ID_valid    = 1'b1;
        ID_rs1      = rs1;
        ID_rs1_used = u1;
        ID_rs2      = rs2;
        ID_rs2_used = u2;
        ID_rd       = rd;
        ID_RegWrite = rw;
        ID_MemRead  = mr;
        ID_Long     = lg;
        #1;
    endtask

    task automatic id_idle();
        ID_valid    = 1'b0;
        ID_rs1      = 5'd0;
        ID_rs1_used = 1'b0;
        ID_rs2      = 5'd0;
        ID_rs2_used = 1'b0;
        ID_rd       = 5'd0;
        ID_RegWrite = 1'b0;
        ID_MemRead  = 1'b0;
        ID_Long     = 1'b0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        ext_stall = 1'b0;
        id_idle();
        tick();
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_bubble", {31'd0, ID_EX_bubble}, 32'd0);
        check("reset_long_busy", {31'd0, long_busy}, 32'd0);
`ifdef HAZARD_STATS_EN
        check("reset_stall_cycles", stall_cycles, 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // 1. load-use: load x5, reader of x5 stalls exactly one cycle
        id_op(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        check("t1_load_issue_stall", {31'd0, stall}, 32'd0);
        tick();
        id_op(5'd5, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        check("t1_use_stall", {31'd0, stall}, 32'd1);
        check("t1_use_bubble", {31'd0, ID_EX_bubble}, 32'd1);
        tick();
        check("t1_use_release", {31'd0, stall}, 32'd0);
        check("t1_use_release_bubble", {31'd0, ID_EX_bubble}, 32'd0);
        tick();

        // 2. ALU producer x6 then reader of x6 on rs2: never stalls
        id_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        check("t2_alu_issue", {31'd0, stall}, 32'd0);
        tick();
        id_op(5'd2, 1'b1, 5'd6, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        check("t2_alu_reader", {31'd0, stall}, 32'd0);
        tick();

        // 3. long op x7, reader stalls, then a second long op hits STRUCT
        id_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1);
        check("t3_long_issue", {31'd0, stall}, 32'd0);
        tick();
        check("t3_long_busy", {31'd0, long_busy}, 32'd1);
        id_op(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("t3_raw_c1", {31'd0, stall}, 32'd1);
        tick();
        check("t3_raw_c2", {31'd0, stall}, 32'd1);
        tick();
        id_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1);
        check("t3_struct_c1", {31'd0, stall}, 32'd1);
        tick();
        check("t3_struct_c2", {31'd0, stall}, 32'd1);
        check("t3_struct_busy", {31'd0, long_busy}, 32'd1);
        tick();
        check("t3_struct_release", {31'd0, stall}, 32'd0);
        check("t3_long_idle", {31'd0, long_busy}, 32'd0);
        tick();
        id_op(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("t3_x7_ready", {31'd0, stall}, 32'd0);
        tick();
        id_idle();
        repeat (5) tick();
        check("t3_drained", {31'd0, long_busy}, 32'd0);

        // 4. WAW behind a long op, then x0 is never tracked
        id_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
        tick();
        id_op(5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("t4_waw_c%0d", c), {31'd0, stall}, 32'd1);
            tick();
        end
        check("t4_waw_release", {31'd0, stall}, 32'd0);
        tick();
        id_idle();
        repeat (5) tick();
        id_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        check("t4_long_x0_issue", {31'd0, stall}, 32'd0);
        tick();
        id_op(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        check("t4_x0_read", {31'd0, stall}, 32'd0);
        check("t4_x0_busy", {31'd0, long_busy}, 32'd1);
        tick();
        id_idle();
        repeat (5) tick();

        // 5. load x9, 3-cycle freeze holds the countdown, then 1-cycle stall
        id_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        id_idle();
        ext_stall = 1'b1;
        repeat (3) tick();
        ext_stall = 1'b0;
        id_op(5'd9, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
        check("t5_after_freeze", {31'd0, stall}, 32'd1);
        tick();
        check("t5_release", {31'd0, stall}, 32'd0);
        tick();

        // flush kills the ID slot but issued counters keep counting
        id_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
        tick();
        flush = 1'b1;
        id_op(5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("flush_stall", {31'd0, stall}, 32'd0);
        check("flush_bubble", {31'd0, ID_EX_bubble}, 32'd1);
        tick();
        flush = 1'b0;
        #1;
        check("flush_counted_down", {31'd0, stall}, 32'd0);
`ifdef HAZARD_STATS_EN
        check("stats_total", stall_cycles, 32'd10);
`endif
        tick();

        // 6. async reset while cnt[x7]=3 drops stall immediately
        id_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1);
        tick();
        id_idle();
        tick();
        id_op(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("t6_pre_reset_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_reset_stall", {31'd0, stall}, 32'd0);
        check("t6_reset_busy", {31'd0, long_busy}, 32'd0);
`ifdef HAZARD_STATS_EN
        check("t6_reset_stats", stall_cycles, 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        check("t6_after_reset", {31'd0, stall}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
